// File: rtl/ipg_tx.sv
// Purpose : replaces eligible all-idle 64b/66b control blocks with side-channel blocks carrying up to 48 user bits.
// Latency : 1 cycle, registered; input block at cycle N appears on out_encoded_tx_* at N+1.
// Backpress: tx_ipg_ready is a registered !full; the block stream itself is never stalled.
//
// Ports:
//   clk, rst                           block clock, synchronous active-high reset
//   encoded_tx_data/hdr                encoder output block (payload bit 0 first, [7:0] block type)
//   out_encoded_tx_data/hdr            block stream after insertion
//   tx_ipg_data/len/valid/ready        side-channel word handshake (len 1..48 valid bits)
//   tx_ipg_enable                      insertion enable; when low the stream passes unchanged
//   tx_ipg_sent_count                  inserted-block count, wraps
//   tx_ipg_err_count                   discarded malformed words, saturates at 255
module ipg_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_IDLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] encoded_tx_data,
    input  logic [1:0]  encoded_tx_hdr,
    output logic [63:0] out_encoded_tx_data,
    output logic [1:0]  out_encoded_tx_hdr,
    input  logic [47:0] tx_ipg_data,
    input  logic [5:0]  tx_ipg_len,
    input  logic        tx_ipg_valid,
    output logic        tx_ipg_ready,
    input  logic        tx_ipg_enable,
    output logic [15:0] tx_ipg_sent_count,
    output logic [7:0]  tx_ipg_err_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int HW = (HOLD_IDLES > 1) ? $clog2(HOLD_IDLES + 1) : 1;
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_IDLES);

    localparam logic [63:0] IDLE_BLK = 64'h0000_0000_0000_001E;
    localparam logic [1:0]  HDR_CTRL = 2'b10;

    typedef enum logic [1:0] {
        ST_DATA   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_INSERT = 2'd2
    } state_t;

    state_t         state;
    logic [HW-1:0]  hold_cnt;

    // Side-channel word buffer: each entry is {len, payload}.
    logic [53:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [AW:0]    count_nxt;

    logic           is_idle;
    logic           eligible;
    logic           replace;
    logic           len_ok;
    logic           accept;
    logic           push;
    logic           pop;
    logic           fifo_vld;
    logic [53:0]    head_dat;
    logic [5:0]     head_len;
    logic [47:0]    head_mask;
    logic [47:0]    head_payload;

    assign is_idle = (encoded_tx_hdr == HDR_CTRL) && (encoded_tx_data == IDLE_BLK);

    // An idle is eligible once HOLD_IDLES idles have already passed since the
    // last non-idle block; with HOLD_IDLES = 0 the very first idle qualifies.
    always_comb begin
        eligible = 1'b0;
        if (is_idle) begin
            case (state)
                ST_INSERT: eligible = 1'b1;
                ST_DATA:   eligible = (HOLD_IDLES == 0);
                default:   eligible = 1'b0;
            endcase
        end
    end

    // Malformed words still complete the handshake but never enter the buffer.
    assign len_ok   = (tx_ipg_len != 6'd0) && (tx_ipg_len <= 6'd48);
    assign accept   = tx_ipg_valid && tx_ipg_ready;
    assign push     = accept && len_ok;
    assign fifo_vld = (count != '0);
    assign replace  = eligible && tx_ipg_enable && fifo_vld;
    assign pop      = replace;

    assign head_dat     = mem[rd_ptr];
    assign head_len     = head_dat[53:48];
    // len = 48 overflows the 48-bit shift to zero, so the subtraction yields all ones.
    assign head_mask    = (48'd1 << head_len) - 48'd1;
    assign head_payload = head_dat[47:0] & head_mask;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tx_ipg_len, tx_ipg_data};
        end
    end

    // Buffer pointers and registered ready; ready reflects occupancy after
    // this cycle's push/pop and is held low while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            tx_ipg_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= count_nxt;
            tx_ipg_ready <= (count_nxt != DEPTH_C);
        end
    end

    // Idle-run tracker. Insertion enable does not affect it, so a later enable
    // resumes with the correct notion of where the stream is.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_DATA;
            hold_cnt <= '0;
        end else if (!is_idle) begin
            state    <= ST_DATA;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_DATA: begin
                    if (HOLD_IDLES == 0) begin
                        state <= ST_INSERT;
                    end else begin
                        hold_cnt <= HW'(1);
                        state    <= (HOLD_IDLES == 1) ? ST_INSERT : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt + 1'b1 == HOLD_MAX) begin
                        state <= ST_INSERT;
                    end
                end
                ST_INSERT: begin
                    state <= ST_INSERT;
                end
                default: begin
                    state    <= ST_DATA;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Output register and counters. Reset overwrites any side-channel block
    // sitting in the output register with the plain idle block.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_encoded_tx_data <= IDLE_BLK;
            out_encoded_tx_hdr  <= HDR_CTRL;
            tx_ipg_sent_count   <= '0;
            tx_ipg_err_count    <= '0;
        end else begin
            if (replace) begin
                out_encoded_tx_data <= {head_payload, 2'b00, head_len, 8'hE1};
                out_encoded_tx_hdr  <= HDR_CTRL;
                tx_ipg_sent_count   <= tx_ipg_sent_count + 16'd1;
            end else begin
                out_encoded_tx_data <= encoded_tx_data;
                out_encoded_tx_hdr  <= encoded_tx_hdr;
            end
            if (accept && !len_ok && (tx_ipg_err_count != 8'hFF)) begin
                tx_ipg_err_count <= tx_ipg_err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ipg_tx.sv
// Purpose : scoreboard bench for ipg_tx against a queue-based reference model.
// Latency : expectations are due one clock after the block is driven.
// Backpress: word offers are held until the model-predicted ready accepts them.
module tb_ipg_tx;

    localparam int FIFO_DEPTH = 4;
    localparam int HOLD_IDLES = 1;
    localparam logic [63:0] IDLE = 64'h1E;

    logic        clk;
    logic        rst;
    logic [63:0] encoded_tx_data;
    logic [1:0]  encoded_tx_hdr;
    logic [63:0] out_encoded_tx_data;
    logic [1:0]  out_encoded_tx_hdr;
    logic [47:0] tx_ipg_data;
    logic [5:0]  tx_ipg_len;
    logic        tx_ipg_valid;
    logic        tx_ipg_ready;
    logic        tx_ipg_enable;
    logic [15:0] tx_ipg_sent_count;
    logic [7:0]  tx_ipg_err_count;

    ipg_tx #(.FIFO_DEPTH(FIFO_DEPTH), .HOLD_IDLES(HOLD_IDLES)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .encoded_tx_data     (encoded_tx_data),
        .encoded_tx_hdr      (encoded_tx_hdr),
        .out_encoded_tx_data (out_encoded_tx_data),
        .out_encoded_tx_hdr  (out_encoded_tx_hdr),
        .tx_ipg_data         (tx_ipg_data),
        .tx_ipg_len          (tx_ipg_len),
        .tx_ipg_valid        (tx_ipg_valid),
        .tx_ipg_ready        (tx_ipg_ready),
        .tx_ipg_enable       (tx_ipg_enable),
        .tx_ipg_sent_count   (tx_ipg_sent_count),
        .tx_ipg_err_count    (tx_ipg_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [63:0] d;
        logic [1:0]  h;
        logic        rdy;
        logic [15:0] sent;
        logic [7:0]  err;
    } exp_t;

    typedef struct {
        logic [47:0] d;
        int          len;
    } word_t;

    exp_t  exp_q[$];
    word_t wq[$];
    int    idle_run;
    int    m_sent;
    int    m_err;
    logic  m_rdy;

    logic        en;
    logic        off_v;
    logic [47:0] off_d;
    logic [5:0]  off_l;
    logic        last_acc;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Side-channel block built bit by bit from the block format definition.
    function automatic logic [63:0] side_blk(input logic [47:0] p, input int len);
        logic [63:0] b;
        b = '0;
        b[7:0] = 8'hE1;
        b[13:8] = len[5:0];
        for (int i = 0; i < 48; i++) begin
            if (i < len) b[16 + i] = p[i];
        end
        return b;
    endfunction

    // One block cycle: drive inputs, advance the model, queue the expected output.
    task automatic step(input logic [63:0] d, input logic [1:0] h);
        exp_t  e;
        word_t w;
        logic  idle_blk, elig, acc;
        rst             = 1'b0;
        encoded_tx_data = d;
        encoded_tx_hdr  = h;
        tx_ipg_valid    = off_v;
        tx_ipg_data     = off_d;
        tx_ipg_len      = off_l;
        tx_ipg_enable   = en;

        idle_blk = (h == 2'b10) && (d == IDLE);
        elig     = idle_blk && (idle_run >= HOLD_IDLES);
        idle_run = idle_blk ? ((idle_run < 1000) ? idle_run + 1 : idle_run) : 0;
        acc      = off_v && m_rdy;

        e.d = d;
        e.h = h;
        if (elig && en && wq.size() > 0) begin
            w      = wq.pop_front();
            e.d    = side_blk(w.d, w.len);
            e.h    = 2'b10;
            m_sent = (m_sent + 1) % 65536;
        end
        if (acc) begin
            if (off_l >= 1 && off_l <= 48) begin
                w.d   = off_d;
                w.len = int'(off_l);
                wq.push_back(w);
            end else if (m_err < 255) begin
                m_err++;
            end
        end
        m_rdy    = (wq.size() < FIFO_DEPTH);
        e.due    = cyc + 1;
        e.rdy    = m_rdy;
        e.sent   = 16'(m_sent);
        e.err    = 8'(m_err);
        exp_q.push_back(e);
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_t e;
        rst             = 1'b1;
        tx_ipg_valid    = 1'b0;
        encoded_tx_data = IDLE;
        encoded_tx_hdr  = 2'b10;
        tx_ipg_enable   = en;
        wq.delete();
        idle_run = 0;
        m_sent   = 0;
        m_err    = 0;
        m_rdy    = 1'b0;
        e.due  = cyc + 1;
        e.d    = IDLE;
        e.h    = 2'b10;
        e.rdy  = 1'b0;
        e.sent = '0;
        e.err  = '0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idles(input int n);
        repeat (n) step(IDLE, 2'b10);
    endtask

    task automatic frame();
        step({56'hD5_5555_5555_5555, 8'h78}, 2'b10);
        step({$urandom, $urandom}, 2'b01);
        step({$urandom, $urandom}, 2'b01);
        step({56'h0, 8'h87}, 2'b10);
    endtask

    // Hold a word on the interface (over data blocks) until accepted.
    task automatic push_word(input logic [47:0] d, input logic [5:0] len);
        int tries;
        off_v = 1'b1;
        off_d = d;
        off_l = len;
        tries = 0;
        last_acc = 1'b0;
        while (!last_acc && tries < 20) begin
            step({$urandom, $urandom}, 2'b01);
            tries++;
        end
        off_v = 1'b0;
        chk("push_word_accepted", 64'(last_acc), 64'd1);
    endtask

    // Monitor: pops the expectation due this cycle and compares all outputs.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            chk("mon_due", 64'(e.due), 64'(cyc));
            chk("mon_out_data", out_encoded_tx_data, e.d);
            chk("mon_out_hdr", 64'(out_encoded_tx_hdr), 64'(e.h));
            chk("mon_ready", 64'(tx_ipg_ready), 64'(e.rdy));
            chk("mon_sent_count", 64'(tx_ipg_sent_count), 64'(e.sent));
            chk("mon_err_count", 64'(tx_ipg_err_count), 64'(e.err));
        end
    end

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [47:0] words [6];
        int k;
        int r;
        en       = 1'b1;
        off_v    = 1'b0;
        off_d    = '0;
        off_l    = '0;
        last_acc = 1'b0;
        idle_run = 0;
        m_sent   = 0;
        m_err    = 0;
        m_rdy    = 1'b0;

        // Reset state
        do_reset();
        chk("rst_out_data", out_encoded_tx_data, 64'h1E);
        chk("rst_out_hdr", 64'(out_encoded_tx_hdr), 64'd2);
        chk("rst_ready", 64'(tx_ipg_ready), 64'd0);
        chk("rst_sent", 64'(tx_ipg_sent_count), 64'd0);
        chk("rst_err", 64'(tx_ipg_err_count), 64'd0);

        // Pass-through with enable low; the queued word must be held.
        en = 1'b0;
        idles(1);
        chk("ready_after_reset", 64'(tx_ipg_ready), 64'd1);
        push_word(48'h1234_5678_9ABC, 6'd40);
        frame();
        idles(10);
        chk("passthru_sent", 64'(tx_ipg_sent_count), 64'd0);
        en = 1'b1;
        idles(1);
        chk("held_word_data", out_encoded_tx_data, {48'h0034_5678_9ABC, 2'b00, 6'd40, 8'hE1});
        chk("held_word_sent", 64'(tx_ipg_sent_count), 64'd1);

        // Single insertion, HOLD_IDLES = 1
        do_reset();
        idles(1);
        push_word(48'hABCD_EF01_2345, 6'd48);
        frame();
        idles(1);
        chk("ins_first_idle", out_encoded_tx_data, 64'h1E);
        idles(1);
        chk("ins_second_data", out_encoded_tx_data, {48'hABCD_EF01_2345, 2'b00, 6'd48, 8'hE1});
        chk("ins_second_hdr", 64'(out_encoded_tx_hdr), 64'd2);
        idles(2);
        chk("ins_rest_idle", out_encoded_tx_data, 64'h1E);
        chk("ins_count", 64'(tx_ipg_sent_count), 64'd1);

        // Masking
        push_word(48'hFFFF_FFFF_FFFF, 6'd5);
        frame();
        idles(2);
        chk("mask_payload", 64'(out_encoded_tx_data[63:16]), 64'h1F);
        chk("mask_len", 64'(out_encoded_tx_data[13:8]), 64'd5);

        // Backpressure / full
        do_reset();
        frame();
        for (int i = 0; i < 6; i++) words[i] = {$urandom, $urandom};
        k = 0;
        for (int c = 0; c < 6; c++) begin
            off_v = 1'b1;
            off_d = words[k];
            off_l = 6'd48;
            step({$urandom, $urandom}, 2'b01);
            if (last_acc) k++;
        end
        off_v = 1'b0;
        chk("bp_accepted", 64'(k), 64'd4);
        chk("bp_ready_low", 64'(tx_ipg_ready), 64'd0);
        idles(1);
        chk("bp_ready_still_low", 64'(tx_ipg_ready), 64'd0);
        idles(1);
        chk("bp_word0", 64'(out_encoded_tx_data[63:16]), 64'(words[0]));
        chk("bp_ready_back", 64'(tx_ipg_ready), 64'd1);
        for (int i = 1; i < 4; i++) begin
            idles(1);
            chk("bp_word_order", 64'(out_encoded_tx_data[63:16]), 64'(words[i]));
        end

        // Malformed words
        do_reset();
        frame();
        push_word(48'h1, 6'd0);
        push_word(48'h1, 6'd49);
        chk("mal_err", 64'(tx_ipg_err_count), 64'd2);
        idles(4);
        chk("mal_no_insert", 64'(tx_ipg_sent_count), 64'd0);
        chk("mal_idle_out", out_encoded_tx_data, 64'h1E);

        // Reset mid-stream with words queued
        do_reset();
        en = 1'b0;
        frame();
        push_word(48'h111111111111, 6'd48);
        push_word(48'h222222222222, 6'd48);
        push_word(48'h333333333333, 6'd48);
        idles(3);
        en = 1'b1;
        idles(1);
        chk("mid_side_out", out_encoded_tx_data, {48'h111111111111, 2'b00, 6'd48, 8'hE1});
        do_reset();
        chk("mid_rst_data", out_encoded_tx_data, 64'h1E);
        chk("mid_rst_ready", 64'(tx_ipg_ready), 64'd0);
        idles(HOLD_IDLES + 2);
        chk("mid_flushed", 64'(tx_ipg_sent_count), 64'd0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            en = ($urandom_range(0, 9) != 0);
            if (!off_v || last_acc) begin
                off_v = ($urandom_range(0, 1) == 1);
                off_d = {$urandom, $urandom};
                r = $urandom_range(0, 9);
                if (r == 0)      off_l = 6'd0;
                else if (r == 1) off_l = 6'($urandom_range(49, 63));
                else             off_l = 6'($urandom_range(1, 48));
            end
            r = $urandom_range(0, 9);
            if (r < 5)       step(IDLE, 2'b10);
            else if (r < 8)  step({$urandom, $urandom}, 2'b01);
            else if (r == 8) step({$urandom, $urandom}, 2'b10);
            else if ($urandom_range(0, 1) == 1)
                step(IDLE | (64'd1 << $urandom_range(8, 63)), 2'b10);
            else
                step(IDLE, 2'($urandom_range(0, 1) * 3));
        end
        off_v = 1'b0;
        idles(3);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
